// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: decoder control bundle layout
// and the constants the decoder and EX stage agree on.
package id_ex_stage_pkg;

    localparam int ALUOP_W = 5;

    localparam int CTRL_JAL        = 0;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_LUI        = 2;
    localparam int CTRL_JALR       = 3;
    localparam int CTRL_WDSEL_LSB  = 4;
    localparam int CTRL_WDSEL_W    = 2;
    localparam int CTRL_DMTYPE_LSB = 6;
    localparam int CTRL_DMTYPE_W   = 3;
    localparam int CTRL_BSRC       = 9;
    localparam int CTRL_ASRC       = 10;
    localparam int CTRL_MEMREAD    = 11;
    localparam int CTRL_MEMWRITE   = 12;
    localparam int CTRL_REGWRITE   = 13;
    localparam int CTRL_ALUOP_LSB  = 14;
    localparam int CTRL_W          = CTRL_ALUOP_LSB + ALUOP_W;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP = '0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = ALUOP_W'(1);

    localparam logic [CTRL_WDSEL_W-1:0] WDSEL_ALU = 2'd0;
    localparam logic [CTRL_WDSEL_W-1:0] WDSEL_MEM = 2'd1;
    localparam logic [CTRL_WDSEL_W-1:0] WDSEL_PC4 = 2'd2;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard comparator: a load in EX feeding a source of the
// instruction in ID forces a one-cycle stall.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       flush,
    input  logic       ex_hold,
    output logic       lu_stall
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_load;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign ex_load = ex_valid && ex_mem_read && (ex_rd != 5'd0);

    // Hold already freezes upstream, so no stall is reported under it.
    assign lu_stall = ex_load && id_valid && (rs1_hit || rs2_hit)
                    && !flush && !ex_hold;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush
// handling across EX holds and a bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              lu_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;
    logic   pend_flush;
    logic   bubble;

    hazard_detect u_hazard (
        .ex_valid    (q.valid),
        .ex_mem_read (q.ctrl[CTRL_MEMREAD]),
        .ex_rd       (q.rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .flush       (flush),
        .ex_hold     (ex_hold),
        .lu_stall    (lu_stall)
    );

    assign bubble = flush || pend_flush || lu_stall;

    always_comb begin
        d.valid    = id_valid;
        d.ctrl     = id_ctrl;
        d.pc       = id_pc;
        d.rs1_data = id_rs1_data;
        d.rs2_data = id_rs2_data;
        d.imm      = id_imm;
        d.rs1      = id_rs1;
        d.rs2      = id_rs2;
        d.rd       = id_rd;
        d.funct3   = id_funct3;
        if (bubble) begin
            d      = '0;
            d.ctrl = CTRL_BUBBLE;
        end
    end

    // A flush seen while EX is held is parked until the first free edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q          <= '0;
            pend_flush <= 1'b0;
            bubble_cnt <= '0;
        end else if (ex_hold) begin
            pend_flush <= pend_flush | flush;
        end else begin
            q          <= d;
            pend_flush <= 1'b0;
            if (bubble) bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign ex_valid    = q.valid;
    assign ex_ctrl     = q.ctrl;
    assign ex_pc       = q.pc;
    assign ex_rs1_data = q.rs1_data;
    assign ex_rs2_data = q.rs2_data;
    assign ex_imm      = q.imm;
    assign ex_rs1      = q.rs1;
    assign ex_rs2      = q.rs2;
    assign ex_rd       = q.rd;
    assign ex_funct3   = q.funct3;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of per-cycle vectors plus
// hand sequences for reset residue, rs1/rs2 masking and counter wrap.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CW    = CTRL_W;

    logic            clk;
    logic            rstn;
    logic            id_valid;
    logic [CW-1:0]   id_ctrl;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [4:0]      id_rd;
    logic [2:0]      id_funct3;
    logic            ex_hold;
    logic            flush;
    logic            ex_valid;
    logic [CW-1:0]   ex_ctrl;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic            lu_stall;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_valid    (id_valid),
        .id_ctrl     (id_ctrl),
        .id_pc       (id_pc),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .id_imm      (id_imm),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_funct3   (id_funct3),
        .ex_hold     (ex_hold),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ctrl     (ex_ctrl),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct3   (ex_funct3),
        .lu_stall    (lu_stall),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rstn, hold, flush, idv;
        logic [CW-1:0] ctrl;
        logic [31:0]   pc, imm;
        logic [4:0]    rs1, rs2;
        logic          u1, u2;
        logic [4:0]    rd;
        logic          e_stall, e_v;
        logic [CW-1:0] e_ctrl;
        logic [31:0]   e_pc, e_imm;
        logic [4:0]    e_rs1, e_rs2, e_rd;
        logic [3:0]    e_cnt;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    logic [CW-1:0] c_addi, c_lw, c_add, c_none;
    vec_t tbl[14];

    function automatic logic [CW-1:0] mkc(input logic rw, input logic mr,
                                          input logic bs, input logic [1:0] wd,
                                          input logic [2:0] dm);
        logic [CW-1:0] c;
        c = '0;
        c[CTRL_REGWRITE] = rw;
        c[CTRL_MEMREAD]  = mr;
        c[CTRL_BSRC]     = bs;
        c[CTRL_WDSEL_LSB +: CTRL_WDSEL_W]   = wd;
        c[CTRL_DMTYPE_LSB +: CTRL_DMTYPE_W] = dm;
        c[CTRL_ALUOP_LSB +: ALUOP_W]        = ALUOP_ADD;
        return c;
    endfunction

    function automatic vec_t row(
        input int rs, input int hd, input int fl, input int iv,
        input logic [CW-1:0] ct, input int pc, input int im,
        input int r1, input int r2, input int u1, input int u2, input int rd,
        input int es, input int ev, input logic [CW-1:0] ect,
        input int epc, input int eim, input int er1, input int er2,
        input int erd, input int ecn);
        vec_t v;
        v.rstn = 1'(rs);  v.hold = 1'(hd); v.flush = 1'(fl); v.idv = 1'(iv);
        v.ctrl = ct;      v.pc = 32'(pc);  v.imm = 32'(im);
        v.rs1 = 5'(r1);   v.rs2 = 5'(r2);
        v.u1 = 1'(u1);    v.u2 = 1'(u2);   v.rd = 5'(rd);
        v.e_stall = 1'(es); v.e_v = 1'(ev); v.e_ctrl = ect;
        v.e_pc = 32'(epc); v.e_imm = 32'(eim);
        v.e_rs1 = 5'(er1); v.e_rs2 = 5'(er2); v.e_rd = 5'(erd);
        v.e_cnt = 4'(ecn);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v, input string tag);
        rstn        = v.rstn;
        ex_hold     = v.hold;
        flush       = v.flush;
        id_valid    = v.idv;
        id_ctrl     = v.ctrl;
        id_pc       = v.pc;
        id_imm      = v.imm;
        id_rs1_data = v.pc * 3;
        id_rs2_data = v.imm * 5;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_use_rs1  = v.u1;
        id_use_rs2  = v.u2;
        id_rd       = v.rd;
        id_funct3   = v.rd[2:0];
        #1;
        if (v.rstn) chk({tag, " lu_stall"}, 32'(lu_stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'(v.e_v));
        chk({tag, " ex_ctrl"}, 32'(ex_ctrl), 32'(v.e_ctrl));
        chk({tag, " ex_pc"}, ex_pc, v.e_pc);
        chk({tag, " ex_imm"}, ex_imm, v.e_imm);
        chk({tag, " ex_rs1_data"}, ex_rs1_data, v.e_pc * 3);
        chk({tag, " ex_rs2_data"}, ex_rs2_data, v.e_imm * 5);
        chk({tag, " ex_rs1"}, 32'(ex_rs1), 32'(v.e_rs1));
        chk({tag, " ex_rs2"}, 32'(ex_rs2), 32'(v.e_rs2));
        chk({tag, " ex_rd"}, 32'(ex_rd), 32'(v.e_rd));
        chk({tag, " ex_funct3"}, 32'(ex_funct3), 32'(v.e_rd[2:0]));
        chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'(v.e_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        c_none = '0;
        c_addi = mkc(1'b1, 1'b0, 1'b1, WDSEL_ALU, 3'd0);
        c_lw   = mkc(1'b1, 1'b1, 1'b1, WDSEL_MEM, 3'd2);
        c_add  = mkc(1'b1, 1'b0, 1'b0, WDSEL_ALU, 3'd0);

        tbl[0]  = row(1,0,0,1, c_addi,'h40,7,1,0,1,0,5,
                      0,1,c_addi,'h40,7,1,0,5,0);
        tbl[1]  = row(1,0,0,1, c_lw,'h44,8,5,0,1,0,6,
                      0,1,c_lw,'h44,8,5,0,6,0);
        tbl[2]  = row(1,0,0,1, c_add,'h48,0,6,1,1,1,7,
                      1,0,c_none,0,0,0,0,0,1);
        tbl[3]  = row(1,0,0,1, c_add,'h48,0,6,1,1,1,7,
                      0,1,c_add,'h48,0,6,1,7,1);
        tbl[4]  = row(1,0,0,1, c_lw,'h4c,4,2,0,1,0,0,
                      0,1,c_lw,'h4c,4,2,0,0,1);
        tbl[5]  = row(1,0,0,1, c_add,'h50,0,0,0,1,1,8,
                      0,1,c_add,'h50,0,0,0,8,1);
        tbl[6]  = row(1,0,0,1, c_lw,'h54,'hc,3,0,1,0,9,
                      0,1,c_lw,'h54,'hc,3,0,9,1);
        tbl[7]  = row(1,0,1,1, c_add,'h58,0,9,2,1,1,10,
                      0,0,c_none,0,0,0,0,0,2);
        tbl[8]  = row(1,0,0,1, c_lw,'h80,'h11,4,0,1,0,11,
                      0,1,c_lw,'h80,'h11,4,0,11,2);
        tbl[9]  = row(1,1,1,1, c_add,'h84,0,11,0,1,0,12,
                      0,1,c_lw,'h80,'h11,4,0,11,2);
        tbl[10] = row(1,1,0,1, c_add,'h84,0,11,0,1,0,12,
                      0,1,c_lw,'h80,'h11,4,0,11,2);
        tbl[11] = row(1,1,0,1, c_add,'h84,0,11,0,1,0,12,
                      0,1,c_lw,'h80,'h11,4,0,11,2);
        tbl[12] = row(1,0,0,0, c_addi,'h90,3,0,0,1,0,13,
                      0,0,c_none,0,0,0,0,0,3);
        tbl[13] = row(1,0,0,1, c_addi,'h90,3,0,0,1,0,13,
                      0,1,c_addi,'h90,3,0,0,13,3);

        // Reset with a valid instruction on the inputs.
        for (int i = 0; i < 2; i++)
            apply(row(0,0,0,1, c_addi,'h40,7,1,0,1,0,5,
                      0,0,c_none,0,0,0,0,0,0), $sformatf("reset%0d", i));

        for (int i = 0; i < 14; i++)
            apply(tbl[i], $sformatf("tbl%0d", i));

        // Pending flush must not survive a reset.
        apply(row(1,1,1,1, c_addi,'h94,0,0,0,0,0,0,
                  0,1,c_addi,'h90,3,0,0,13,3), "pend_set");
        apply(row(0,0,0,1, c_addi,'h94,0,0,0,0,0,0,
                  0,0,c_none,0,0,0,0,0,0), "pend_rst");
        apply(row(1,0,0,1, c_addi,'ha0,5,2,0,1,0,14,
                  0,1,c_addi,'ha0,5,2,0,14,0), "pend_gone");

        // Reset in the middle of a load-use hazard.
        apply(row(1,0,0,1, c_lw,'ha4,6,14,0,1,0,15,
                  0,1,c_lw,'ha4,6,14,0,15,0), "lu_load");
        apply(row(0,0,0,1, c_add,'ha8,0,15,15,1,1,16,
                  0,0,c_none,0,0,0,0,0,0), "lu_rst");
        apply(row(1,0,0,1, c_add,'ha8,0,15,15,1,1,16,
                  0,1,c_add,'ha8,0,15,15,16,0), "lu_after");

        // rs2-only hazard, then unused sources that match ex_rd.
        apply(row(1,0,0,1, c_lw,'hac,1,0,0,1,0,17,
                  0,1,c_lw,'hac,1,0,0,17,0), "rs2_load");
        apply(row(1,0,0,1, c_add,'hb0,0,17,17,0,1,18,
                  1,0,c_none,0,0,0,0,0,1), "rs2_hit");
        apply(row(1,0,0,1, c_add,'hb0,0,17,17,0,1,18,
                  0,1,c_add,'hb0,0,17,17,18,1), "rs2_replay");
        apply(row(1,0,0,1, c_lw,'hb4,2,0,0,0,0,19,
                  0,1,c_lw,'hb4,2,0,0,19,1), "mask_load");
        apply(row(1,0,0,1, c_addi,'hb8,9,19,19,0,0,20,
                  0,1,c_addi,'hb8,9,19,19,20,1), "mask_nouse");

        // Counter wrap: 17 flushes on a 4-bit counter.
        apply(row(0,0,0,0, c_none,0,0,0,0,0,0,0,
                  0,0,c_none,0,0,0,0,0,0), "wrap_rst");
        for (int i = 0; i < 17; i++)
            apply(row(1,0,1,1, c_addi,'hc0,1,0,0,1,0,21,
                      0,0,c_none,0,0,0,0,0,(i + 1) % 16),
                  $sformatf("wrap%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
